// File: rtl/capture_burst_buffer.sv
// capture_burst_buffer: elastic FIFO between the sample packer and the FX3
// slave-FIFO write engine. Captures a fixed number of whole bursts per arm,
// only ever exposes complete bursts, and reports overflow and progress.
module capture_burst_buffer #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_LOG2  = 11,
   parameter int BURST_WORDS = 1024
) (
   input  logic                  clk_pll,
   input  logic                  reset_,
   input  logic                  arm,
   input  logic [31:0]           pkt_count,
   input  logic                  abort,
   input  logic                  smp_valid,
   input  logic [DATA_W-1:0]     smp_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [DEPTH_LOG2:0]   level,
   output logic [31:0]           bursts_sent
);

   localparam int BW_LOG2 = $clog2(BURST_WORDS);
   localparam int ACC_W   = 32 + BW_LOG2;
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int PTR_W   = DEPTH_LOG2 + 1;

   localparam logic [PTR_W-1:0]   FULL_LVL  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0]   BURST_LVL = PTR_W'(BURST_WORDS);
   localparam logic [BW_LOG2-1:0] LAST_BEAT = BW_LOG2'(BURST_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          target_q, target_d;
   logic [ACC_W-1:0]     acc_cnt_q, acc_cnt_d;
   logic [31:0]          bursts_sent_q, bursts_sent_d;
   logic                 overflow_q, overflow_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic                 burst_active_q, burst_active_d;
   logic [BW_LOG2-1:0]   beat_q, beat_d;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic [DATA_W-1:0]    head_q;

   logic [PTR_W-1:0]     level_w;
   logic                 full_w;
   logic                 push_w;
   logic                 pop_w;
   logic                 beat_last_w;
   logic [ACC_W-1:0]     acc_inc_w;
   logic [ACC_W-1:0]     acc_target_w;

   assign level_w      = wr_ptr_q - rd_ptr_q;
   assign full_w       = (level_w == FULL_LVL);
   // Abort flushes the FIFO, so neither side may move the pointers that cycle.
   assign push_w       = (state_q == S_CAPTURE) && smp_valid && !full_w && !abort;
   assign pop_w        = burst_active_q && out_ready && !abort;
   assign beat_last_w  = (beat_q == LAST_BEAT);
   assign acc_inc_w    = acc_cnt_q + ACC_W'(1);
   assign acc_target_w = ACC_W'(target_q) << BW_LOG2;

   // Next-state logic: FSM, FIFO pointers, burst gating and status counters.
   always_comb begin
      state_d        = state_q;
      target_d       = target_q;
      acc_cnt_d      = acc_cnt_q;
      bursts_sent_d  = bursts_sent_q;
      overflow_d     = overflow_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      burst_active_d = burst_active_q;
      beat_d         = beat_q;

      if (abort) begin
         // Flush and return to idle; status counters keep their values.
         state_d        = S_IDLE;
         wr_ptr_d       = '0;
         rd_ptr_d       = '0;
         burst_active_d = 1'b0;
         beat_d         = '0;
      end else begin
         if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end

         // A burst is launched only once a whole burst is resident, and then
         // stays valid until every one of its words has been handshaken.
         if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (beat_last_w) begin
               beat_d         = '0;
               burst_active_d = 1'b0;
               bursts_sent_d  = bursts_sent_q + 32'd1;
            end else begin
               beat_d = beat_q + BW_LOG2'(1);
            end
         end else if (!burst_active_q && (level_w >= BURST_LVL) &&
                      ((state_q == S_CAPTURE) || (state_q == S_DRAIN))) begin
            burst_active_d = 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  target_d      = pkt_count;
                  acc_cnt_d     = '0;
                  bursts_sent_d = '0;
                  overflow_d    = 1'b0;
                  state_d       = (pkt_count == 32'd0) ? S_DONE : S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (smp_valid && full_w) begin
                  overflow_d = 1'b1;
               end
               if (push_w) begin
                  acc_cnt_d = acc_inc_w;
                  if (acc_inc_w == acc_target_w) begin
                     state_d = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (bursts_sent_q == target_q) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Control and status registers, cleared asynchronously by reset_.
   always_ff @(posedge clk_pll or negedge reset_) begin
      if (!reset_) begin
         state_q        <= S_IDLE;
         target_q       <= '0;
         acc_cnt_q      <= '0;
         bursts_sent_q  <= '0;
         overflow_q     <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         burst_active_q <= 1'b0;
         beat_q         <= '0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         acc_cnt_q      <= acc_cnt_d;
         bursts_sent_q  <= bursts_sent_d;
         overflow_q     <= overflow_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         burst_active_q <= burst_active_d;
         beat_q         <= beat_d;
      end
   end

   // Sample RAM with a registered read that prefetches the next head. The
   // prefetched address is never the one being written while a burst is live,
   // because a live burst always has its remaining words already resident.
   always_ff @(posedge clk_pll) begin
      if (push_w) begin
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= smp_data;
      end
      head_q <= mem[rd_ptr_d[DEPTH_LOG2-1:0]];
   end

   assign out_valid   = burst_active_q;
   assign out_data    = burst_active_q ? head_q : '0;
   assign out_last    = burst_active_q && beat_last_w;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign overflow    = overflow_q;
   assign level       = level_w;
   assign bursts_sent = bursts_sent_q;

endmodule

// File: tb/tb_capture_burst_buffer.sv
// Directed testbench for capture_burst_buffer with 4-word bursts and an
// 8-word FIFO. Inputs change and outputs are observed on the falling edge.
module tb_capture_burst_buffer;

   localparam int DW = 32;
   localparam int DL = 3;
   localparam int BW = 4;

   logic            clk_pll   = 1'b0;
   logic            reset_    = 1'b0;
   logic            arm       = 1'b0;
   logic [31:0]     pkt_count = '0;
   logic            abort     = 1'b0;
   logic            smp_valid = 1'b0;
   logic [DW-1:0]   smp_data  = '0;
   logic            out_ready = 1'b0;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            overflow;
   logic [DL:0]     level;
   logic [31:0]     bursts_sent;

   capture_burst_buffer #(
      .DATA_W      (DW),
      .DEPTH_LOG2  (DL),
      .BURST_WORDS (BW)
   ) dut (
      .clk_pll     (clk_pll),
      .reset_      (reset_),
      .arm         (arm),
      .pkt_count   (pkt_count),
      .abort       (abort),
      .smp_valid   (smp_valid),
      .smp_data    (smp_data),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .level       (level),
      .bursts_sent (bursts_sent)
   );

   always #5 clk_pll = ~clk_pll;

   int total = 0;
   int bad   = 0;

   int            got_data[$];
   bit            got_last[$];
   int            done_cnt;
   int            hold_viol;
   int            first_vld;
   logic [DW-1:0] data_hist [64];
   logic          vld_hist  [64];
   logic [DL:0]   lvl_hist  [64];
   logic          ovf_hist  [64];
   logic          busy_hist [64];

   // Arm on one rising edge (edge 0) with the sample stream idle.
   task automatic do_arm(input logic [31:0] n);
      @(negedge clk_pll);
      arm = 1'b1; pkt_count = n; smp_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk_pll);
      #1 arm = 1'b0;
   endtask

   // Streams data base, base+1, ... one per edge (edge c gets base+c-1) and
   // records observations made after edge c-1 at index c. rmode: 0 ready
   // always, 1 ready only from edge 21, 2 ready on odd edges, 3 never ready.
   task automatic run_traffic(input int iters, input int base, input int rmode,
                              input int abort_at);
      logic          pv, pr;
      logic [DW-1:0] pd;
      got_data.delete(); got_last.delete();
      done_cnt = 0; hold_viol = 0; first_vld = -1;
      pv = 1'b0; pr = 1'b0; pd = '0;
      for (int c = 1; c <= iters; c++) begin
         @(negedge clk_pll);
         if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) hold_viol++;
         data_hist[c] = out_data; vld_hist[c] = out_valid; lvl_hist[c] = level;
         ovf_hist[c] = overflow;  busy_hist[c] = busy;
         if (done === 1'b1) done_cnt++;
         if (out_valid === 1'b1 && first_vld < 0) first_vld = c;
         smp_valid = 1'b1;
         smp_data  = DW'(base + c - 1);
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c > 20);
            2:       out_ready = (c % 2 == 1);
            default: out_ready = 1'b0;
         endcase
         abort = (c == abort_at);
         if (out_valid === 1'b1 && out_ready && !abort) begin
            got_data.push_back(int'(out_data));
            got_last.push_back(out_last);
            $display("  xfer t=%0t data=%0d last=%0b level=%0d", $time, out_data, out_last, level);
         end
         pv = out_valid; pr = out_ready; pd = out_data;
      end
      @(negedge clk_pll);
      smp_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_pll);
      total++;
      if ({out_valid, out_last, busy, done, overflow, level, bursts_sent, out_data} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0",
                  {out_valid, out_last, busy, done, overflow, level, bursts_sent, out_data});
      end
      reset_ = 1'b1;
      @(negedge clk_pll);
      total++;
      if ({busy, out_valid, level} !== '0) begin
         bad++;
         $display("FAIL reset_release_idle got busy=%0b valid=%0b level=%0d want 0/0/0", busy, out_valid, level);
      end
   endtask

   task automatic test_basic();
      int exp_n;
      logic [7:0] mask;
      do_arm(2);
      run_traffic(25, 1, 0, 0);
      // Four words are resident after edge 4; the burst launches on edge 5.
      total++;
      if (first_vld !== 6) begin
         bad++; $display("FAIL basic_first_valid got=%0d want=6", first_vld);
      end
      total++;
      if (got_data.size() !== 8) begin
         bad++; $display("FAIL basic_count got=%0d want=8", got_data.size());
      end
      mask = '0;
      for (int i = 0; i < 8; i++) begin
         exp_n = i + 1;
         total++;
         if (i >= got_data.size() || got_data[i] !== exp_n) begin
            bad++; $display("FAIL basic_data[%0d] got=%0d want=%0d", i,
                            (i < got_data.size()) ? got_data[i] : -1, exp_n);
         end
         if (i < got_last.size()) mask[i] = got_last[i];
      end
      total++;
      if (mask !== 8'b1000_1000) begin
         bad++; $display("FAIL basic_last_mask got=%b want=10001000", mask);
      end
      total++;
      if (done_cnt !== 1 || bursts_sent !== 32'd2 || overflow !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_status got done=%0d sent=%0d ovf=%0b busy=%0b want 1/2/0/0",
                         done_cnt, bursts_sent, overflow, busy);
      end
   endtask

   task automatic test_backpressure();
      int exp_d[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 22, 23, 24, 25};
      logic [11:0] mask;
      do_arm(3);
      run_traffic(45, 1, 1, 0);
      total++;
      if (lvl_hist[9] !== 4'd8 || ovf_hist[9] !== 1'b0) begin
         bad++; $display("FAIL bp_fill got level=%0d ovf=%0b want 8/0", lvl_hist[9], ovf_hist[9]);
      end
      total++;
      if (lvl_hist[21] !== 4'd8 || ovf_hist[21] !== 1'b1 || vld_hist[21] !== 1'b1 || data_hist[21] !== 32'd1) begin
         bad++; $display("FAIL bp_stalled got level=%0d ovf=%0b valid=%0b head=%0d want 8/1/1/1",
                         lvl_hist[21], ovf_hist[21], vld_hist[21], data_hist[21]);
      end
      total++;
      if (got_data.size() !== 12) begin
         bad++; $display("FAIL bp_count got=%0d want=12", got_data.size());
      end
      mask = '0;
      for (int i = 0; i < 12; i++) begin
         total++;
         if (i >= got_data.size() || got_data[i] !== exp_d[i]) begin
            bad++; $display("FAIL bp_data[%0d] got=%0d want=%0d", i,
                            (i < got_data.size()) ? got_data[i] : -1, exp_d[i]);
         end
         if (i < got_last.size()) mask[i] = got_last[i];
      end
      total++;
      if (mask !== 12'h888) begin
         bad++; $display("FAIL bp_last_mask got=%h want=888", mask);
      end
      total++;
      if (done_cnt !== 1 || bursts_sent !== 32'd3 || overflow !== 1'b1) begin
         bad++; $display("FAIL bp_status got done=%0d sent=%0d ovf=%0b want 1/3/1", done_cnt, bursts_sent, overflow);
      end
   endtask

   task automatic test_zero_count();
      do_arm(0);
      @(negedge clk_pll);
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL zero_done_cycle got done=%0b busy=%0b valid=%0b want 1/1/0", done, busy, out_valid);
      end
      @(negedge clk_pll);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL zero_after got done=%0b busy=%0b valid=%0b want 0/0/0", done, busy, out_valid);
      end
   endtask

   task automatic test_abort();
      logic [3:0] mask;
      do_arm(2);
      run_traffic(20, 1, 0, 7);
      total++;
      if (vld_hist[7] !== 1'b1 || data_hist[7] !== 32'd2) begin
         bad++; $display("FAIL abort_pre got valid=%0b head=%0d want 1/2", vld_hist[7], data_hist[7]);
      end
      total++;
      if (vld_hist[8] !== 1'b0 || lvl_hist[8] !== 4'd0 || busy_hist[8] !== 1'b0) begin
         bad++; $display("FAIL abort_next got valid=%0b level=%0d busy=%0b want 0/0/0",
                         vld_hist[8], lvl_hist[8], busy_hist[8]);
      end
      total++;
      if (done_cnt !== 0 || got_data.size() !== 1 || lvl_hist[20] !== 4'd0 || bursts_sent !== 32'd0) begin
         bad++; $display("FAIL abort_quiet got done=%0d xfers=%0d level=%0d sent=%0d want 0/1/0/0",
                         done_cnt, got_data.size(), lvl_hist[20], bursts_sent);
      end
      do_arm(1);
      run_traffic(15, 101, 0, 0);
      mask = '0;
      total++;
      if (got_data.size() !== 4) begin
         bad++; $display("FAIL rearm_count got=%0d want=4", got_data.size());
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (i >= got_data.size() || got_data[i] !== 101 + i) begin
            bad++; $display("FAIL rearm_data[%0d] got=%0d want=%0d", i,
                            (i < got_data.size()) ? got_data[i] : -1, 101 + i);
         end
         if (i < got_last.size()) mask[i] = got_last[i];
      end
      total++;
      if (mask !== 4'b1000 || done_cnt !== 1 || bursts_sent !== 32'd1) begin
         bad++; $display("FAIL rearm_status got mask=%b done=%0d sent=%0d want 1000/1/1", mask, done_cnt, bursts_sent);
      end
   endtask

   task automatic test_toggle_ready();
      logic [7:0] mask;
      do_arm(2);
      run_traffic(45, 1, 2, 0);
      total++;
      if (hold_viol !== 0) begin
         bad++; $display("FAIL toggle_hold got=%0d stalls_changed want=0", hold_viol);
      end
      total++;
      if (got_data.size() !== 8) begin
         bad++; $display("FAIL toggle_count got=%0d want=8", got_data.size());
      end
      mask = '0;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i >= got_data.size() || got_data[i] !== i + 1) begin
            bad++; $display("FAIL toggle_data[%0d] got=%0d want=%0d", i,
                            (i < got_data.size()) ? got_data[i] : -1, i + 1);
         end
         if (i < got_last.size()) mask[i] = got_last[i];
      end
      total++;
      if (mask !== 8'b1000_1000 || done_cnt !== 1 || overflow !== 1'b0) begin
         bad++; $display("FAIL toggle_status got mask=%b done=%0d ovf=%0b want 10001000/1/0", mask, done_cnt, overflow);
      end
   endtask

   task automatic test_async_reset();
      do_arm(2);
      run_traffic(12, 1, 3, 0);
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || level !== 4'd8) begin
         bad++; $display("FAIL areset_setup got busy=%0b valid=%0b level=%0d want 1/1/8", busy, out_valid, level);
      end
      #2 reset_ = 1'b0;
      #1;
      total++;
      if ({out_valid, out_last, busy, done, overflow, level, bursts_sent, out_data} !== '0) begin
         bad++;
         $display("FAIL areset_immediate got=%h want=0",
                  {out_valid, out_last, busy, done, overflow, level, bursts_sent, out_data});
      end
      @(negedge clk_pll);
      reset_ = 1'b1;
      for (int c = 0; c < 6; c++) begin
         smp_valid = 1'b1;
         smp_data  = DW'(200 + c);
         @(negedge clk_pll);
         total++;
         if (level !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL areset_idle[%0d] got level=%0d busy=%0b valid=%0b want 0/0/0",
                            c, level, busy, out_valid);
         end
      end
      smp_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_count();
      test_abort();
      test_toggle_ready();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/capture_burst_buffer.md
Name: capture_burst_buffer

Overview:
- Elastic buffer between the logic-analyser sample packer (8 channels, packed 4 samples per 32-bit word, one word per clk_pll) and the FX3 slave-FIFO write engine.
- Captures exactly pkt_count bursts of BURST_WORDS words per arm command, absorbs FX3 back-pressure (FLAGA/FLAGB waits), and presents whole bursts only.
- Reports overflow and progress for the Nios/VIO status path.

Parameters:
- DATA_W, 32, sample word width.
- DEPTH_LOG2, 11, FIFO depth = 2^DEPTH_LOG2 words (2048). Must be >= log2(BURST_WORDS)+1.
- BURST_WORDS, 1024, words per FX3 DMA buffer (4 KB). Power of two.

Ports:
- clk_pll  in  1  system clock.
- reset_  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle start pulse; latches pkt_count.
- pkt_count  in  32  number of bursts to capture.
- abort  in  1  single-cycle cancel pulse.
- smp_valid  in  1  sample word strobe.
- smp_data  in  DATA_W  packed sample word.
- out_ready  in  1  write engine accepts a word this cycle.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  show-ahead FIFO head.
- out_last  out  1  final word of the current burst.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on completion.
- overflow  out  1  sticky: a sample was dropped.
- level  out  DEPTH_LOG2+1  FIFO occupancy.
- bursts_sent  out  32  completed bursts since the last arm.

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0; out_data 0.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE -> CAPTURE: on arm with pkt_count != 0. On that edge:
  - latch target = pkt_count;
  - clear bursts_sent, overflow, and the internal accepted-word counter (width 32+log2(BURST_WORDS)).
- IDLE -> DONE: on arm with pkt_count == 0. Emits done; produces no output.
- arm while busy: ignored; latched values are unchanged.
- Accepting samples (CAPTURE only):
  - Accept when smp_valid && level != 2^DEPTH_LOG2.
  - If smp_valid while full: drop the word, set overflow. A dropped word does not count as accepted.
  - smp_valid is ignored in IDLE, DRAIN and DONE.
- CAPTURE -> DRAIN: on the cycle the accepted count reaches target*BURST_WORDS. That final word is accepted.
- DRAIN -> DONE: when bursts_sent == target.
- DONE -> IDLE: unconditional, 1 cycle; done=1 only in DONE.
- Abort: from any state returns to IDLE next cycle.
  - Flush the FIFO (level=0); drop out_valid next cycle.
  - No done pulse; bursts_sent and overflow hold their values.
  - Abort wins over a simultaneous arm.
- Burst gating:
  - A burst starts only when level >= BURST_WORDS and no burst is in progress. A partial burst is never exposed.
  - Once started, out_valid = 1 until BURST_WORDS handshakes (out_valid && out_ready) complete.
  - out_last = 1 on the word where the in-burst counter == BURST_WORDS-1.
  - The in-burst counter wraps to 0 after out_last; bursts_sent increments on the out_last handshake.
  - The next burst may start the following cycle if level allows.
- Data path:
  - out_data shows the FIFO head and is stable while out_valid && !out_ready.
  - Write-to-visible latency: a word accepted at edge N is counted in level after edge N and can be read from edge N+1 onwards.
- Simultaneous push and pop: level unchanged; the FIFO never loses or duplicates a word.
- Full and empty: push when full follows the overflow rule. Pop never occurs when empty, because gating guarantees occupancy.
- Pointers: DEPTH_LOG2+1 bits wide, natural wrap-around; level = wr_ptr - rd_ptr.

Test Plan:
1. BURST_WORDS=4, DEPTH_LOG2=3, arm pkt_count=2, smp_valid continuous with data 1,2,3…, out_ready=1:
   - out_valid first rises after 4 words accepted;
   - outputs 1..8, out_last on 4 and 8;
   - bursts_sent=2; done pulses once; overflow=0.
2. Same config, out_ready=0 for 20 cycles while capturing 3 bursts:
   - level saturates at 8; overflow=1;
   - FIFO holds words 1..8;
   - capture still completes 12 accepted words;
   - all 12 accepted words are emitted in order.
3. arm pkt_count=0 -> done pulses the cycle after arm, busy=1 for exactly 1 cycle, out_valid never asserts.
4. Abort mid-burst (word 2 of burst 1 outstanding):
   - next cycle: out_valid=0, level=0, busy=0, no done;
   - a re-arm with pkt_count=1 then produces a clean 4-word burst.
5. Toggle out_ready 1/0 every cycle:
   - out_data holds during stalls;
   - no duplicates or skips;
   - out_last is aligned to the 4th handshake of each burst.
6. Async reset asserted mid-DRAIN:
   - all outputs 0 immediately;
   - after release, state IDLE and smp_valid is ignored until arm.
